// File: rtl/cpu_inst_loader.sv
// UART boot loader: parses framed records and writes 18-bit words to instruction RAM.
// Optional trailing checksum byte when CPU_INST_LOADER_CSUM_EN is defined.
module cpu_inst_loader #(
   parameter logic [7:0] SYNC_BYTE   = 8'hA5,
   parameter int         TIMEOUT_CYC = 1000000,
   parameter int         ADDR_W      = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic              rx_ready,
   output logic              inst_update,
   output logic [ADDR_W-1:0] inst_address,
   output logic [17:0]       inst_data_out,
   output logic              cpu_hold,
   output logic              busy,
   output logic              load_done,
   output logic              load_err
);

   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   localparam int HW = ADDR_W - 8;

   typedef enum logic [3:0] {
      S_IDLE,
      S_ADDR_H,
      S_ADDR_L,
      S_LEN,
      S_B0,
      S_B1,
      S_B2,
      S_WRITE,
`ifdef CPU_INST_LOADER_CSUM_EN
      S_CSUM,
`endif
      S_DONE
   } state_t;

   state_t r_state;
   state_t w_next;

   logic [TW-1:0]     r_tmo;
   logic [HW-1:0]     r_addr_h;
   logic [ADDR_W-1:0] r_addr;
   logic [8:0]        r_cnt;
   logic [7:0]        r_low;
   logic [7:0]        r_high;
   logic [ADDR_W-1:0] r_addr_out;
   logic [17:0]       r_data_out;
   logic              r_hold;
   logic              r_err;
`ifdef CPU_INST_LOADER_CSUM_EN
   logic [7:0]        r_sum;
   logic [7:0]        w_sum_fin;
`endif

   logic w_acc;
   logic w_sync;
   logic w_tmo;
   logic w_wait;
   logic w_err;

   assign rx_ready = (r_state != S_WRITE) && (r_state != S_DONE);
   assign w_acc    = rx_valid & rx_ready;
   assign w_sync   = (r_state == S_IDLE) && w_acc && (rx_data == SYNC_BYTE);
   assign w_tmo    = (r_tmo == TW'(TIMEOUT_CYC - 1));
   assign w_wait   = (r_state != S_IDLE) && rx_ready;
`ifdef CPU_INST_LOADER_CSUM_EN
   assign w_sum_fin = r_sum + rx_data;
`endif

   always_comb begin
      w_next = r_state;
      w_err  = 1'b0;
      unique case (r_state)
         S_IDLE:   if (w_sync) w_next = S_ADDR_H;
         S_ADDR_H: if (w_acc) w_next = S_ADDR_L;
         S_ADDR_L: if (w_acc) w_next = S_LEN;
         S_LEN:    if (w_acc) w_next = S_B0;
         S_B0:     if (w_acc) w_next = S_B1;
         S_B1:     if (w_acc) w_next = S_B2;
         S_B2:     if (w_acc) w_next = S_WRITE;
         S_WRITE: begin
            if (r_cnt != 9'd1)
               w_next = S_B0;
            else
`ifdef CPU_INST_LOADER_CSUM_EN
               w_next = S_CSUM;
`else
               w_next = S_DONE;
`endif
         end
`ifdef CPU_INST_LOADER_CSUM_EN
         S_CSUM: begin
            if (w_acc) begin
               if (w_sum_fin == 8'd0) begin
                  w_next = S_DONE;
               end else begin
                  w_next = S_IDLE;
                  w_err  = 1'b1;
               end
            end
         end
`endif
         S_DONE:   w_next = S_IDLE;
         default:  w_next = S_IDLE;
      endcase
      // inter-byte gap too long: abandon frame, keep words already written
      if (w_wait && !w_acc && w_tmo) begin
         w_next = S_IDLE;
         w_err  = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_tmo      <= '0;
         r_addr_h   <= '0;
         r_addr     <= '0;
         r_cnt      <= '0;
         r_low      <= '0;
         r_high     <= '0;
         r_addr_out <= '0;
         r_data_out <= '0;
         r_hold     <= 1'b0;
         r_err      <= 1'b0;
`ifdef CPU_INST_LOADER_CSUM_EN
         r_sum      <= '0;
`endif
      end else begin
         r_state <= w_next;

         if (w_acc || r_state == S_IDLE)
            r_tmo <= '0;
         else if (!w_tmo)
            r_tmo <= r_tmo + 1'b1;

         if (r_state == S_DONE)
            r_hold <= 1'b0;
         if (w_sync) begin
            r_hold <= 1'b1;
            r_err  <= 1'b0;
         end
         if (w_err) begin
            r_hold <= 1'b0;
            r_err  <= 1'b1;
         end

`ifdef CPU_INST_LOADER_CSUM_EN
         if (r_state == S_IDLE)
            r_sum <= '0;
         else if (w_acc)
            r_sum <= w_sum_fin;
`endif

         if (r_state == S_WRITE) begin
            r_addr <= r_addr + 1'b1;
            r_cnt  <= r_cnt - 1'b1;
         end

         if (w_acc) begin
            unique case (r_state)
               S_ADDR_H: r_addr_h <= rx_data[HW-1:0];
               S_ADDR_L: r_addr   <= {r_addr_h, rx_data};
               S_LEN:    r_cnt    <= {rx_data == 8'd0, rx_data};
               S_B0:     r_low    <= rx_data;
               S_B1:     r_high   <= rx_data;
               S_B2: begin
                  r_addr_out <= r_addr;
                  r_data_out <= {rx_data[1:0], r_high, r_low};
               end
               default: ;
            endcase
         end
      end
   end

   assign inst_update   = (r_state == S_WRITE);
   assign inst_address  = r_addr_out;
   assign inst_data_out = r_data_out;
   assign cpu_hold      = r_hold;
   assign busy          = (r_state != S_IDLE);
   assign load_done     = (r_state == S_DONE);
   assign load_err      = r_err;

endmodule

// File: tb/tb_cpu_inst_loader.sv
// Directed bench for cpu_inst_loader; checksum scenarios are
// built when CPU_INST_LOADER_CSUM_EN is defined.
`timescale 1ns/1ps
module tb_cpu_inst_loader;

   localparam int TMO = 64;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  rx_data = 8'h00;
   logic        rx_valid = 1'b0;
   logic        rx_ready;
   logic        inst_update;
   logic [9:0]  inst_address;
   logic [17:0] inst_data_out;
   logic        cpu_hold;
   logic        busy;
   logic        load_done;
   logic        load_err;

   int vec = 0;
   int err = 0;
   int wr_n = 0;
   int done_n = 0;
   logic [9:0]  wr_a [8];
   logic [17:0] wr_d [8];
   logic [7:0]  fq [$];

   cpu_inst_loader #(
      .SYNC_BYTE   (8'hA5),
      .TIMEOUT_CYC (TMO),
      .ADDR_W      (10)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .rx_data       (rx_data),
      .rx_valid      (rx_valid),
      .rx_ready      (rx_ready),
      .inst_update   (inst_update),
      .inst_address  (inst_address),
      .inst_data_out (inst_data_out),
      .cpu_hold      (cpu_hold),
      .busy          (busy),
      .load_done     (load_done),
      .load_err      (load_err)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (inst_update) begin
         if (wr_n < 8) begin
            wr_a[wr_n] = inst_address;
            wr_d[wr_n] = inst_data_out;
         end
         wr_n++;
      end
      if (load_done) done_n++;
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic send_byte(input logic [7:0] b);
      int n;
      n = 0;
      @(negedge clk);
      rx_data  = b;
      rx_valid = 1'b1;
      while (!rx_ready && n < 16) begin
         @(negedge clk);
         n++;
      end
      if (!rx_ready) begin
         vec++; err++;
         $display("FAIL rx_ready_wait got=%b exp=1", rx_ready);
      end
      @(posedge clk);
      #1 rx_valid = 1'b0;
   endtask

   task automatic send_fq();
      foreach (fq[i]) send_byte(fq[i]);
   endtask

   function automatic logic [7:0] csum_of();
      logic [7:0] s;
      s = 8'h00;
      foreach (fq[i]) s = s + fq[i];
      return 8'h00 - s;
   endfunction

   task automatic send_csum(input logic [7:0] c);
`ifdef CPU_INST_LOADER_CSUM_EN
      send_byte(c);
`else
      if (c === 8'hxx) $display("unused");
`endif
   endtask

   task automatic settle();
      repeat (4) @(negedge clk);
   endtask

   task automatic clr();
      wr_n = 0;
      done_n = 0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      vec++; if (rx_ready !== 1'b1) begin err++; $display("FAIL rst_rx_ready got=%b exp=1", rx_ready); end
      vec++; if (inst_update !== 1'b0) begin err++; $display("FAIL rst_update got=%b exp=0", inst_update); end
      vec++; if (inst_address !== 10'h000) begin err++; $display("FAIL rst_addr got=%h exp=000", inst_address); end
      vec++; if (inst_data_out !== 18'h0) begin err++; $display("FAIL rst_data got=%h exp=00000", inst_data_out); end
      vec++; if (cpu_hold !== 1'b0) begin err++; $display("FAIL rst_hold got=%b exp=0", cpu_hold); end
      vec++; if (busy !== 1'b0) begin err++; $display("FAIL rst_busy got=%b exp=0", busy); end
      vec++; if (load_done !== 1'b0) begin err++; $display("FAIL rst_done got=%b exp=0", load_done); end
      vec++; if (load_err !== 1'b0) begin err++; $display("FAIL rst_err got=%b exp=0", load_err); end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_single_word();
      logic [7:0] c;
      clr();
      send_byte(8'hA5);
      vec++; if (cpu_hold !== 1'b1) begin err++; $display("FAIL single_hold got=%b exp=1", cpu_hold); end
      vec++; if (busy !== 1'b1) begin err++; $display("FAIL single_busy got=%b exp=1", busy); end
      fq = '{8'h00, 8'h10, 8'h01, 8'h34, 8'h12, 8'h03};
      c = csum_of();
      send_fq();
      vec++; if (inst_update !== 1'b1) begin err++; $display("FAIL single_latency got=%b exp=1", inst_update); end
      vec++; if (inst_address !== 10'h010) begin err++; $display("FAIL single_addr got=%h exp=010", inst_address); end
      vec++; if (inst_data_out !== 18'h31234) begin err++; $display("FAIL single_data got=%h exp=31234", inst_data_out); end
      vec++; if (rx_ready !== 1'b0) begin err++; $display("FAIL single_ready_wr got=%b exp=0", rx_ready); end
      send_csum(c);
      settle();
      vec++; if (wr_n !== 1) begin err++; $display("FAIL single_nwr got=%0d exp=1", wr_n); end
      vec++; if (done_n !== 1) begin err++; $display("FAIL single_done got=%0d exp=1", done_n); end
      vec++; if (load_err !== 1'b0) begin err++; $display("FAIL single_err got=%b exp=0", load_err); end
      vec++; if (cpu_hold !== 1'b0) begin err++; $display("FAIL single_hold_end got=%b exp=0", cpu_hold); end
      vec++; if (busy !== 1'b0) begin err++; $display("FAIL single_busy_end got=%b exp=0", busy); end
   endtask

   task automatic test_wrap();
      logic [7:0] c;
      clr();
      send_byte(8'hA5);
      fq = '{8'h03, 8'hFE, 8'h03,
             8'h01, 8'h00, 8'h00,
             8'h02, 8'h00, 8'h01,
             8'h03, 8'h00, 8'h02};
      c = csum_of();
      send_fq();
      send_csum(c);
      settle();
      vec++; if (wr_n !== 3) begin err++; $display("FAIL wrap_nwr got=%0d exp=3", wr_n); end
      vec++; if (wr_a[0] !== 10'h3FE) begin err++; $display("FAIL wrap_a0 got=%h exp=3fe", wr_a[0]); end
      vec++; if (wr_a[1] !== 10'h3FF) begin err++; $display("FAIL wrap_a1 got=%h exp=3ff", wr_a[1]); end
      vec++; if (wr_a[2] !== 10'h000) begin err++; $display("FAIL wrap_a2 got=%h exp=000", wr_a[2]); end
      vec++; if (wr_d[0] !== 18'h00001) begin err++; $display("FAIL wrap_d0 got=%h exp=00001", wr_d[0]); end
      vec++; if (wr_d[1] !== 18'h10002) begin err++; $display("FAIL wrap_d1 got=%h exp=10002", wr_d[1]); end
      vec++; if (wr_d[2] !== 18'h20003) begin err++; $display("FAIL wrap_d2 got=%h exp=20003", wr_d[2]); end
      vec++; if (done_n !== 1) begin err++; $display("FAIL wrap_done got=%0d exp=1", done_n); end
      vec++; if (inst_address !== 10'h000) begin err++; $display("FAIL wrap_hold_addr got=%h exp=000", inst_address); end
   endtask

   task automatic test_timeout();
      clr();
      send_byte(8'hA5);
      fq = '{8'h00, 8'h20, 8'h01, 8'h55, 8'h66};
      send_fq();
      repeat (TMO / 2) @(negedge clk);
      vec++; if (busy !== 1'b1) begin err++; $display("FAIL tmo_busy_mid got=%b exp=1", busy); end
      vec++; if (load_err !== 1'b0) begin err++; $display("FAIL tmo_err_mid got=%b exp=0", load_err); end
      vec++; if (cpu_hold !== 1'b1) begin err++; $display("FAIL tmo_hold_mid got=%b exp=1", cpu_hold); end
      repeat (TMO) @(negedge clk);
      vec++; if (load_err !== 1'b1) begin err++; $display("FAIL tmo_err got=%b exp=1", load_err); end
      vec++; if (cpu_hold !== 1'b0) begin err++; $display("FAIL tmo_hold got=%b exp=0", cpu_hold); end
      vec++; if (busy !== 1'b0) begin err++; $display("FAIL tmo_busy got=%b exp=0", busy); end
      vec++; if (wr_n !== 0) begin err++; $display("FAIL tmo_nwr got=%0d exp=0", wr_n); end
      vec++; if (done_n !== 0) begin err++; $display("FAIL tmo_done got=%0d exp=0", done_n); end
   endtask

   task automatic test_garbage();
      logic [7:0] c;
      clr();
      send_byte(8'h00);
      send_byte(8'hFF);
      send_byte(8'h5A);
      vec++; if (busy !== 1'b0) begin err++; $display("FAIL garb_busy got=%b exp=0", busy); end
      send_byte(8'hA5);
      vec++; if (load_err !== 1'b0) begin err++; $display("FAIL garb_err_clr got=%b exp=0", load_err); end
      fq = '{8'h01, 8'h23, 8'h01, 8'hAA, 8'hBB, 8'hFE};
      c = csum_of();
      send_fq();
      send_csum(c);
      settle();
      vec++; if (wr_n !== 1) begin err++; $display("FAIL garb_nwr got=%0d exp=1", wr_n); end
      vec++; if (wr_a[0] !== 10'h123) begin err++; $display("FAIL garb_addr got=%h exp=123", wr_a[0]); end
      vec++; if (wr_d[0] !== 18'h2BBAA) begin err++; $display("FAIL garb_data got=%h exp=2bbaa", wr_d[0]); end
      vec++; if (done_n !== 1) begin err++; $display("FAIL garb_done got=%0d exp=1", done_n); end
      vec++; if (load_err !== 1'b0) begin err++; $display("FAIL garb_err got=%b exp=0", load_err); end
   endtask

   task automatic test_reset_midframe();
      logic [7:0] c;
      clr();
      send_byte(8'hA5);
      fq = '{8'h00, 8'h40, 8'h01, 8'h77, 8'h88};
      send_fq();
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      vec++; if (rx_ready !== 1'b1) begin err++; $display("FAIL mrst_ready got=%b exp=1", rx_ready); end
      vec++; if (inst_update !== 1'b0) begin err++; $display("FAIL mrst_update got=%b exp=0", inst_update); end
      vec++; if (inst_address !== 10'h000) begin err++; $display("FAIL mrst_addr got=%h exp=000", inst_address); end
      vec++; if (inst_data_out !== 18'h0) begin err++; $display("FAIL mrst_data got=%h exp=00000", inst_data_out); end
      vec++; if (cpu_hold !== 1'b0) begin err++; $display("FAIL mrst_hold got=%b exp=0", cpu_hold); end
      vec++; if (busy !== 1'b0) begin err++; $display("FAIL mrst_busy got=%b exp=0", busy); end
      vec++; if (load_err !== 1'b0) begin err++; $display("FAIL mrst_err got=%b exp=0", load_err); end
      @(negedge clk);
      rst = 1'b0;
      vec++; if (wr_n !== 0) begin err++; $display("FAIL mrst_partial got=%0d exp=0", wr_n); end
      send_byte(8'hA5);
      fq = '{8'h00, 8'h50, 8'h01, 8'h11, 8'h22, 8'h01};
      c = csum_of();
      send_fq();
      send_csum(c);
      settle();
      vec++; if (wr_n !== 1) begin err++; $display("FAIL mrst_nwr got=%0d exp=1", wr_n); end
      vec++; if (wr_a[0] !== 10'h050) begin err++; $display("FAIL mrst_addr2 got=%h exp=050", wr_a[0]); end
      vec++; if (wr_d[0] !== 18'h12211) begin err++; $display("FAIL mrst_data2 got=%h exp=12211", wr_d[0]); end
      vec++; if (done_n !== 1) begin err++; $display("FAIL mrst_done got=%0d exp=1", done_n); end
   endtask

`ifdef CPU_INST_LOADER_CSUM_EN
   task automatic test_csum();
      // 00+00+01+11+22+01 = 0x35, so 0xCB closes the sum to zero
      clr();
      send_byte(8'hA5);
      fq = '{8'h00, 8'h00, 8'h01, 8'h11, 8'h22, 8'h01, 8'hCB};
      send_fq();
      settle();
      vec++; if (done_n !== 1) begin err++; $display("FAIL csum_ok_done got=%0d exp=1", done_n); end
      vec++; if (load_err !== 1'b0) begin err++; $display("FAIL csum_ok_err got=%b exp=0", load_err); end
      clr();
      send_byte(8'hA5);
      fq = '{8'h00, 8'h00, 8'h01, 8'h11, 8'h22, 8'h01, 8'hCC};
      send_fq();
      settle();
      vec++; if (done_n !== 0) begin err++; $display("FAIL csum_bad_done got=%0d exp=0", done_n); end
      vec++; if (load_err !== 1'b1) begin err++; $display("FAIL csum_bad_err got=%b exp=1", load_err); end
      vec++; if (cpu_hold !== 1'b0) begin err++; $display("FAIL csum_bad_hold got=%b exp=0", cpu_hold); end
      vec++; if (wr_n !== 1) begin err++; $display("FAIL csum_bad_nwr got=%0d exp=1", wr_n); end
      vec++; if (wr_d[0] !== 18'h12211) begin err++; $display("FAIL csum_bad_data got=%h exp=12211", wr_d[0]); end
   endtask
`endif

   initial begin
      test_reset();
      test_single_word();
      test_wrap();
      test_timeout();
      test_garbage();
      test_reset_midframe();
`ifdef CPU_INST_LOADER_CSUM_EN
      test_csum();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vec, err);
      $finish;
   end

endmodule
